// File: rtl/enc_pkg.sv
// Shared types and encoding constants for the MIPS instruction encoder.
// ENC_LI_EXPAND_EN enables the two-word li expansion in the files that import this.
package enc_pkg;

  typedef enum logic [3:0] {
    KIND_ADDU  = 4'd0,
    KIND_SUBU  = 4'd1,
    KIND_AND   = 4'd2,
    KIND_OR    = 4'd3,
    KIND_SLTU  = 4'd4,
    KIND_LW    = 4'd5,
    KIND_SW    = 4'd6,
    KIND_BEQ   = 4'd7,
    KIND_ADDIU = 4'd8,
    KIND_J     = 4'd9,
    KIND_LUI   = 4'd10,
    KIND_ORI   = 4'd11,
    KIND_BLTZ  = 4'd12,
    KIND_LI    = 4'd13
  } req_kind_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_KIND  = 2'd2
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT    = 2'd1,
    ST_EMIT_LO = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-word channels of the encoder, with the encoder as slave.
interface instr_encoder_if #(parameter int ADDR_W = 6);

  // Both channels: a transfer happens on a rising edge where valid && ready;
  // the producer holds valid and payload stable until that edge.
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_kind;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [31:0]       req_imm;
  logic              word_valid;
  logic              word_ready;
  logic [31:0]       word_data;
  logic [ADDR_W-1:0] word_addr;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, word_ready,
    input  req_ready, word_valid, word_data, word_addr, err, err_code
  );

  modport slave (
    input  req_valid, req_kind, req_rs, req_rt, req_rd, req_imm, word_ready,
    output req_ready, word_valid, word_data, word_addr, err, err_code
  );

endinterface

// File: rtl/instr_field_pack.sv
// Combinational field packer: request fields to a 32-bit MIPS word plus range/kind errors.
// ENC_LI_EXPAND_EN adds the li expansion outputs (second word and its flag).
module instr_field_pack
  import enc_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
`ifdef ENC_LI_EXPAND_EN
  output logic        o_two_word,
  output logic [31:0] o_lo_word,
`endif
  output logic        o_range_err,
  output logic        o_kind_err
);

  logic w_s16_ok;
  logic w_u16_ok;
  logic w_j_ok;

  assign w_s16_ok = (i_imm[31:15] == 17'h00000) || (i_imm[31:15] == 17'h1FFFF);
  assign w_u16_ok = (i_imm[31:16] == 16'h0000);
  assign w_j_ok   = (i_imm[31:26] == 6'd0);

  always_comb begin
    o_word      = 32'd0;
    o_range_err = 1'b0;
    o_kind_err  = 1'b0;
`ifdef ENC_LI_EXPAND_EN
    o_two_word  = 1'b0;
    o_lo_word   = 32'd0;
`endif
    case (i_kind)
      KIND_ADDU:  o_word = enc_r(i_rs, i_rt, i_rd, FN_ADDU);
      KIND_SUBU:  o_word = enc_r(i_rs, i_rt, i_rd, FN_SUBU);
      KIND_AND:   o_word = enc_r(i_rs, i_rt, i_rd, FN_AND);
      KIND_OR:    o_word = enc_r(i_rs, i_rt, i_rd, FN_OR);
      KIND_SLTU:  o_word = enc_r(i_rs, i_rt, i_rd, FN_SLTU);
      KIND_LW: begin
        o_word      = enc_i(OP_LW, i_rs, i_rt, i_imm[15:0]);
        o_range_err = !w_s16_ok;
      end
      KIND_SW: begin
        o_word      = enc_i(OP_SW, i_rs, i_rt, i_imm[15:0]);
        o_range_err = !w_s16_ok;
      end
      KIND_BEQ: begin
        o_word      = enc_i(OP_BEQ, i_rs, i_rt, i_imm[15:0]);
        o_range_err = !w_s16_ok;
      end
      KIND_ADDIU: begin
        o_word      = enc_i(OP_ADDIU, i_rs, i_rt, i_imm[15:0]);
        o_range_err = !w_s16_ok;
      end
      KIND_BLTZ: begin
        o_word      = enc_i(OP_BLTZ, i_rs, 5'd0, i_imm[15:0]);
        o_range_err = !w_s16_ok;
      end
      KIND_ORI: begin
        o_word      = enc_i(OP_ORI, i_rs, i_rt, i_imm[15:0]);
        o_range_err = !w_u16_ok;
      end
      KIND_LUI: begin
        o_word      = enc_i(OP_LUI, 5'd0, i_rt, i_imm[15:0]);
        o_range_err = !w_u16_ok;
      end
      KIND_J: begin
        o_word      = {OP_J, i_imm[25:0]};
        o_range_err = !w_j_ok;
      end
`ifdef ENC_LI_EXPAND_EN
      KIND_LI: begin
        // Small constants need only ori from $0; otherwise lui, then ori unless low half is zero
        if (w_u16_ok) begin
          o_word = enc_i(OP_ORI, 5'd0, i_rt, i_imm[15:0]);
        end else begin
          o_word     = enc_i(OP_LUI, 5'd0, i_rt, i_imm[31:16]);
          o_two_word = (i_imm[15:0] != 16'h0000);
          o_lo_word  = enc_i(OP_ORI, i_rt, i_rt, i_imm[15:0]);
        end
      end
`endif
      default: o_kind_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder: FSM, registered outputs and the word write pointer.
// ENC_LI_EXPAND_EN builds the EMIT_LO state and second-word register for li.
module instr_encoder
  import enc_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  instr_encoder_if.slave  bus,
  output state_e          o_state
);

  state_e            r_state, w_state_nxt;
  logic              r_word_valid, w_word_valid_nxt;
  logic [31:0]       r_word_data, w_word_data_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic              r_err, w_err_nxt;
  err_code_e         r_err_code, w_err_code_nxt;

  logic [31:0] w_pack_word;
  logic        w_range_err;
  logic        w_kind_err;
  logic        w_final;
  logic        w_word_hs;
  logic        w_accept;

`ifdef ENC_LI_EXPAND_EN
  logic        r_lo_pending, w_lo_pending_nxt;
  logic [31:0] r_lo_word, w_lo_word_nxt;
  logic        w_two_word;
  logic [31:0] w_pack_lo;
`endif

  instr_field_pack u_pack (
    .i_kind      (bus.req_kind),
    .i_rs        (bus.req_rs),
    .i_rt        (bus.req_rt),
    .i_rd        (bus.req_rd),
    .i_imm       (bus.req_imm),
    .o_word      (w_pack_word),
`ifdef ENC_LI_EXPAND_EN
    .o_two_word  (w_two_word),
    .o_lo_word   (w_pack_lo),
`endif
    .o_range_err (w_range_err),
    .o_kind_err  (w_kind_err)
  );

  // The presented word is the last one of its request unless the li low half is still queued
`ifdef ENC_LI_EXPAND_EN
  assign w_final = ((r_state == ST_EMIT) && !r_lo_pending) || (r_state == ST_EMIT_LO);
`else
  assign w_final = (r_state == ST_EMIT);
`endif

  assign w_word_hs     = r_word_valid && bus.word_ready;
  assign bus.req_ready = (r_state == ST_IDLE) || (w_final && bus.word_ready);
  assign w_accept      = bus.req_valid && bus.req_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_word_valid_nxt = r_word_valid;
    w_word_data_nxt  = r_word_data;
    w_ptr_nxt        = r_ptr;
    w_err_nxt        = 1'b0;
    w_err_code_nxt   = r_err_code;
`ifdef ENC_LI_EXPAND_EN
    w_lo_pending_nxt = r_lo_pending;
    w_lo_word_nxt    = r_lo_word;
`endif
    if (w_word_hs) begin
      w_ptr_nxt = r_ptr + 1'b1;
    end
    if (w_accept) begin
      if (w_kind_err || w_range_err) begin
        w_err_nxt        = 1'b1;
        w_err_code_nxt   = w_kind_err ? ERR_KIND : ERR_RANGE;
        w_state_nxt      = ST_IDLE;
        w_word_valid_nxt = 1'b0;
      end else begin
        w_err_code_nxt   = ERR_NONE;
        w_state_nxt      = ST_EMIT;
        w_word_valid_nxt = 1'b1;
        w_word_data_nxt  = w_pack_word;
`ifdef ENC_LI_EXPAND_EN
        w_lo_pending_nxt = w_two_word;
        w_lo_word_nxt    = w_pack_lo;
`endif
      end
    end else if (w_word_hs) begin
`ifdef ENC_LI_EXPAND_EN
      if ((r_state == ST_EMIT) && r_lo_pending) begin
        w_state_nxt      = ST_EMIT_LO;
        w_word_data_nxt  = r_lo_word;
        w_lo_pending_nxt = 1'b0;
      end else begin
        w_state_nxt      = ST_IDLE;
        w_word_valid_nxt = 1'b0;
      end
`else
      w_state_nxt      = ST_IDLE;
      w_word_valid_nxt = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_word_valid <= 1'b0;
      r_word_data  <= 32'd0;
      r_ptr        <= '0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
`ifdef ENC_LI_EXPAND_EN
      r_lo_pending <= 1'b0;
      r_lo_word    <= 32'd0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_word_data  <= w_word_data_nxt;
      r_ptr        <= w_ptr_nxt;
      r_err        <= w_err_nxt;
      r_err_code   <= w_err_code_nxt;
`ifdef ENC_LI_EXPAND_EN
      r_lo_pending <= w_lo_pending_nxt;
      r_lo_word    <= w_lo_word_nxt;
`endif
    end
  end

  assign bus.word_valid = r_word_valid;
  assign bus.word_data  = r_word_data;
  assign bus.word_addr  = r_ptr;
  assign bus.err        = r_err;
  assign bus.err_code   = r_err_code;
  assign o_state        = r_state;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: encoding table, stall/back-to-back, wrap and reset cases.
// Expectations for li follow ENC_LI_EXPAND_EN.
module tb_instr_encoder;
  import enc_pkg::*;

  localparam int ADDR_W = 6;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  state_e dbg_state;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [1:0]  code;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W-1:0]  exp_ptr = '0;
  logic [1:0]         cur_code = 2'd0;
  logic               chk_err = 1'b0;
  logic [1:0]         chk_code = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard and error-pulse monitor, sampled on the falling edge
  initial begin
    logic [ADDR_W+31:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk_err = 1'b0;
      end else begin
        if (chk_err) begin
          check("err_pulse", {31'd0, bus.err}, {31'd0, (chk_code != 2'd0)});
          check("err_code", {30'd0, bus.err_code}, {30'd0, chk_code});
        end
        chk_err  = bus.req_valid && bus.req_ready;
        chk_code = cur_code;
        if (bus.word_valid && bus.word_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL word_unexpected: got 0x%08h at addr %0d, expected no word",
                     bus.word_data, bus.word_addr);
          end else begin
            e = exp_q.pop_front();
            check("word_data", bus.word_data, e[31:0]);
            check("word_addr", {{(32-ADDR_W){1'b0}}, bus.word_addr},
                  {{(32-ADDR_W){1'b0}}, e[ADDR_W+31:32]});
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] imm, input int nw,
                      input logic [31:0] w0, input logic [31:0] w1, input logic [1:0] code,
                      output int waited);
    if (nw > 0) begin
      exp_q.push_back({exp_ptr, w0});
      exp_ptr = exp_ptr + 1'b1;
    end
    if (nw > 1) begin
      exp_q.push_back({exp_ptr, w1});
      exp_ptr = exp_ptr + 1'b1;
    end
    bus.req_valid = 1'b1;
    bus.req_kind  = kind;
    bus.req_rs    = rs;
    bus.req_rt    = rt;
    bus.req_rd    = rd;
    bus.req_imm   = imm;
    cur_code      = code;
    waited        = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_accept_timeout: req_ready low for %0d cycles, expected acceptance", waited);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.word_valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        vecs[$];
    int          w;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a_word;
    logic [ADDR_W-1:0] a_addr;

    bus.req_valid  = 1'b0;
    bus.req_kind   = 4'd0;
    bus.req_rs     = 5'd0;
    bus.req_rt     = 5'd0;
    bus.req_rd     = 5'd0;
    bus.req_imm    = 32'd0;
    bus.word_ready = 1'b1;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    check("rst_word_data", bus.word_data, 32'd0);
    check("rst_word_addr", {26'd0, bus.word_addr}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_err_code", {30'd0, bus.err_code}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // kind, rs, rt, rd, imm, words, word0, word1, err_code
    vecs.push_back('{KIND_ADDU,  5'd1,  5'd2,  5'd3,  32'h00000000, 1, 32'h00221821, 32'h0, 2'd0});
    vecs.push_back('{KIND_LW,    5'd29, 5'd8,  5'd0,  32'hFFFFFFFC, 1, 32'h8FA8FFFC, 32'h0, 2'd0});
    vecs.push_back('{KIND_J,     5'd0,  5'd0,  5'd0,  32'h00400000, 1, 32'h08400000, 32'h0, 2'd0});
    vecs.push_back('{KIND_SUBU,  5'd6,  5'd7,  5'd5,  32'h00000000, 1, 32'h00C72823, 32'h0, 2'd0});
    vecs.push_back('{KIND_AND,   5'd31, 5'd31, 5'd31, 32'h00000000, 1, 32'h03FFF824, 32'h0, 2'd0});
    vecs.push_back('{KIND_OR,    5'd0,  5'd0,  5'd1,  32'h00000000, 1, 32'h00000825, 32'h0, 2'd0});
    vecs.push_back('{KIND_SLTU,  5'd3,  5'd4,  5'd2,  32'h00000000, 1, 32'h0064102B, 32'h0, 2'd0});
    vecs.push_back('{KIND_ADDIU, 5'd1,  5'd1,  5'd0,  32'h00008000, 0, 32'h0,        32'h0, 2'd1});
    vecs.push_back('{KIND_SW,    5'd29, 5'd9,  5'd0,  32'h00007FFF, 1, 32'hAFA97FFF, 32'h0, 2'd0});
    vecs.push_back('{KIND_BEQ,   5'd1,  5'd2,  5'd0,  32'hFFFF8000, 1, 32'h10228000, 32'h0, 2'd0});
    vecs.push_back('{KIND_ADDIU, 5'd5,  5'd4,  5'd0,  32'hFFFFFFFF, 1, 32'h24A4FFFF, 32'h0, 2'd0});
    vecs.push_back('{KIND_ORI,   5'd2,  5'd3,  5'd0,  32'h0000FFFF, 1, 32'h3443FFFF, 32'h0, 2'd0});
    vecs.push_back('{KIND_ORI,   5'd2,  5'd3,  5'd0,  32'h00010000, 0, 32'h0,        32'h0, 2'd1});
    vecs.push_back('{KIND_LUI,   5'd9,  5'd7,  5'd0,  32'h0000ABCD, 1, 32'h3C07ABCD, 32'h0, 2'd0});
    vecs.push_back('{KIND_BLTZ,  5'd10, 5'd5,  5'd0,  32'hFFFFFFFE, 1, 32'h0540FFFE, 32'h0, 2'd0});
    vecs.push_back('{KIND_J,     5'd0,  5'd0,  5'd0,  32'h03FFFFFF, 1, 32'h0BFFFFFF, 32'h0, 2'd0});
    vecs.push_back('{KIND_J,     5'd0,  5'd0,  5'd0,  32'h04000000, 0, 32'h0,        32'h0, 2'd1});
    vecs.push_back('{KIND_LW,    5'd1,  5'd2,  5'd0,  32'hFFFF7FFF, 0, 32'h0,        32'h0, 2'd1});
    vecs.push_back('{4'd14,      5'd1,  5'd2,  5'd3,  32'h00000000, 0, 32'h0,        32'h0, 2'd2});
    vecs.push_back('{4'd15,      5'd1,  5'd2,  5'd3,  32'h00000000, 0, 32'h0,        32'h0, 2'd2});
`ifdef ENC_LI_EXPAND_EN
    vecs.push_back('{KIND_LI,    5'd0,  5'd4,  5'd0,  32'h12345678, 2, 32'h3C041234, 32'h34845678, 2'd0});
    vecs.push_back('{KIND_LI,    5'd0,  5'd4,  5'd0,  32'h00010000, 1, 32'h3C040001, 32'h0, 2'd0});
    vecs.push_back('{KIND_LI,    5'd0,  5'd6,  5'd0,  32'h0000BEEF, 1, 32'h3406BEEF, 32'h0, 2'd0});
`else
    vecs.push_back('{KIND_LI,    5'd0,  5'd4,  5'd0,  32'h12345678, 0, 32'h0,        32'h0, 2'd2});
`endif
    vecs.push_back('{KIND_ADDU,  5'd1,  5'd2,  5'd3,  32'h00000000, 1, 32'h00221821, 32'h0, 2'd0});

    foreach (vecs[i]) begin
      send(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm,
           vecs[i].nw, vecs[i].w0, vecs[i].w1, vecs[i].code, w);
    end
    drain();

    // Consumer stall for three cycles with a request queued behind the word
    bus.word_ready = 1'b0;
    a_word = 32'h00221821;
    a_addr = exp_ptr;
    send(KIND_ADDU, 5'd1, 5'd2, 5'd3, 32'd0, 1, a_word, 32'h0, 2'd0, w);
    bus.req_valid = 1'b1;
    bus.req_kind  = KIND_OR;
    bus.req_rs    = 5'd4;
    bus.req_rt    = 5'd5;
    bus.req_rd    = 5'd6;
    bus.req_imm   = 32'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_word_valid", {31'd0, bus.word_valid}, 32'd1);
      check("stall_word_data", bus.word_data, a_word);
      check("stall_word_addr", {26'd0, bus.word_addr}, {26'd0, a_addr});
      check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.word_ready = 1'b1;
    send(KIND_OR, 5'd4, 5'd5, 5'd6, 32'd0, 1, 32'h00853025, 32'h0, 2'd0, w);
    check("release_accept_wait", w, 32'd0);
    send(KIND_SUBU, 5'd6, 5'd7, 5'd5, 32'd0, 1, 32'h00C72823, 32'h0, 2'd0, w);
    check("back_to_back_wait", w, 32'd0);
    @(negedge clk);
    check("back_to_back_valid", {31'd0, bus.word_valid}, 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Walk the pointer to the top of the address space, then cross the wrap
    while (exp_ptr != 6'd63) begin
      rs = 5'($urandom_range(31));
      rt = 5'($urandom_range(31));
      rd = 5'($urandom_range(31));
      send(KIND_ADDU, rs, rt, rd, 32'd0, 1, {6'b000000, rs, rt, rd, 5'd0, 6'b100001}, 32'h0,
           2'd0, w);
    end
    send(KIND_AND, 5'd31, 5'd31, 5'd31, 32'd0, 1, 32'h03FFF824, 32'h0, 2'd0, w);
    send(KIND_J, 5'd0, 5'd0, 5'd0, 32'h00400000, 1, 32'h08400000, 32'h0, 2'd0, w);
    drain();

    // Reset while a multi-cycle word sequence is in flight
    bus.word_ready = 1'b0;
`ifdef ENC_LI_EXPAND_EN
    send(KIND_LI, 5'd0, 5'd4, 5'd0, 32'h12345678, 2, 32'h3C041234, 32'h34845678, 2'd0, w);
    bus.word_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.word_ready = 1'b0;
    @(negedge clk);
    check("li_lo_presented", bus.word_data, 32'h34845678);
    check("li_lo_state", {30'd0, dbg_state}, {30'd0, ST_EMIT_LO});
`else
    send(KIND_ADDU, 5'd1, 5'd2, 5'd3, 32'd0, 1, 32'h00221821, 32'h0, 2'd0, w);
    @(negedge clk);
    check("pre_reset_valid", {31'd0, bus.word_valid}, 32'd1);
`endif
    #2 reset_n = 1'b0;
    #1;
    check("midrst_word_valid", {31'd0, bus.word_valid}, 32'd0);
    check("midrst_word_addr", {26'd0, bus.word_addr}, 32'd0);
    check("midrst_word_data", bus.word_data, 32'd0);
    check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("midrst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    exp_q.delete();
    exp_ptr = '0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus.word_ready = 1'b1;
    send(KIND_ADDU, 5'd1, 5'd2, 5'd3, 32'd0, 1, 32'h00221821, 32'h0, 2'd0, w);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
